// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state type and default geometry for the parametrised register file
package reg_file_pkg;
  typedef enum logic {IDLE, CLEAR} state_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_ADDR_W = 3;
endpackage

// File: rtl/reg_file_clear_fsm.sv
// reg_file_clear_fsm: sweep-clear sequencer that walks every address once and flags writes that arrive while busy
module reg_file_clear_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              wr,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy,
  output logic              wr_drop
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic drop_q, drop_d;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    drop_d = (state_q == CLEAR) && wr;
    if (state_q == IDLE && clr) begin
      state_d = CLEAR;
      ptr_d = '0;
    end
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      state_d = (ptr_q == '1) ? IDLE : CLEAR;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      drop_q <= drop_d;
    end
  end
  assign busy = state_q == CLEAR;
  assign clr_en = busy;
  assign clr_addr = ptr_q;
  assign wr_drop = drop_q;
endmodule

// File: rtl/param_reg_file.sv
// param_reg_file: 2-read/1-write register file with per-entry valid bits, write bypass and sweep clear
module param_reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b,
  output logic              valid_a,
  output logic              valid_b,
  input  logic              clr,
  output logic              busy,
  output logic              wr_drop
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic clr_en, wr_en, hit_a, hit_b;
  logic [ADDR_W-1:0] clr_addr;
  reg_file_clear_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr(wr),
    .clr_en(clr_en), .clr_addr(clr_addr), .busy(busy), .wr_drop(wr_drop)
  );
  // With a hardwired zero register, entry 0 is never written, so it stays 0/invalid with no read-side masking
  assign wr_en = wr && !busy && reset_n && !(ZERO_REG != 0 && wr_addr == '0);
  always_comb begin
    mem_d = mem_q;
    valid_d = valid_q;
    if (wr_en) begin
      mem_d[wr_addr] = d_in;
      valid_d[wr_addr] = 1'b1;
    end
    if (clr_en) begin
      mem_d[clr_addr] = '0;
      valid_d[clr_addr] = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      valid_q <= '0;
    end else begin
      mem_q <= mem_d;
      valid_q <= valid_d;
    end
  end
  assign hit_a = BYPASS != 0 && wr_en && wr_addr == rd_addr_a;
  assign hit_b = BYPASS != 0 && wr_en && wr_addr == rd_addr_b;
  assign d_out_a = hit_a ? d_in : mem_q[rd_addr_a];
  assign d_out_b = hit_b ? d_in : mem_q[rd_addr_b];
  assign valid_a = hit_a || valid_q[rd_addr_a];
  assign valid_b = hit_b || valid_q[rd_addr_b];
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: scoreboard bench for the default build and a ZERO_REG=1, BYPASS=0, 32x16 build
module tb_param_reg_file;
  logic clk = 0, reset_n = 0;
  logic wr = 0, clr = 0;
  logic [2:0] wr_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic [15:0] d_in = 0, d_out_a, d_out_b;
  logic valid_a, valid_b, busy, wr_drop;
  logic z_wr = 0, z_clr = 0;
  logic [3:0] z_wr_addr = 0, z_rd_a = 0, z_rd_b = 0;
  logic [31:0] z_d_in = 0, z_d_out_a, z_d_out_b;
  logic z_valid_a, z_valid_b, z_busy, z_wr_drop;
  int errors = 0, checks = 0;
  logic [15:0] m_mem [8];
  logic m_val [8];
  logic [31:0] zm_mem [16];
  logic zm_val [16];
  logic [65:0] sb [$];
  logic [65:0] exp_v, obs;

  param_reg_file dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .d_out_a(d_out_a), .d_out_b(d_out_b),
    .valid_a(valid_a), .valid_b(valid_b), .clr(clr), .busy(busy), .wr_drop(wr_drop)
  );
  param_reg_file #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut_z (
    .clk(clk), .reset_n(reset_n), .wr(z_wr), .wr_addr(z_wr_addr), .d_in(z_d_in),
    .rd_addr_a(z_rd_a), .rd_addr_b(z_rd_b), .d_out_a(z_d_out_a), .d_out_b(z_d_out_b),
    .valid_a(z_valid_a), .valid_b(z_valid_b), .clr(z_clr), .busy(z_busy), .wr_drop(z_wr_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_val[i] = 1'b0; end
    for (int i = 0; i < 16; i++) begin zm_mem[i] = '0; zm_val[i] = 1'b0; end
  endtask

  task automatic drive_rd(input int a, input int b);
    rd_addr_a = 3'(a);
    rd_addr_b = 3'(b);
    sb.push_back({32'(m_mem[a]), m_val[a], 32'(m_mem[b]), m_val[b]});
  endtask

  task automatic drive_zrd(input int a, input int b);
    z_rd_a = 4'(a);
    z_rd_b = 4'(b);
    sb.push_back({zm_mem[a], zm_val[a], zm_mem[b], zm_val[b]});
  endtask

  task automatic wr_cycle(input int a, input logic [15:0] d);
    wr = 1; wr_addr = 3'(a); d_in = d;
    step();
    wr = 0;
    m_mem[a] = d; m_val[a] = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    wr = 1; wr_addr = 1; d_in = 16'hFFFF;
    drive_rd(1, 0);
    drive_zrd(0, 15);
    @(negedge clk);
    exp_v = sb.pop_front(); obs = {32'(d_out_a), valid_a, 32'(d_out_b), valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_rd: got %h exp %h", obs, exp_v); end
    exp_v = sb.pop_front(); obs = {z_d_out_a, z_valid_a, z_d_out_b, z_valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_zrd: got %h exp %h", obs, exp_v); end
    checks++;
    if ({busy, wr_drop, z_busy, z_wr_drop} !== 4'b0) begin
      errors++; $display("FAIL reset_ctl: got %b exp 0000", {busy, wr_drop, z_busy, z_wr_drop});
    end
    wr = 0;
    reset_n = 1;
    step();
  endtask

  task automatic test_write_read();
    wr_cycle(0, 16'hABCD);
    drive_rd(0, 1);
    @(negedge clk);
    exp_v = sb.pop_front(); obs = {32'(d_out_a), valid_a, 32'(d_out_b), valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wr_rd: got %h exp %h", obs, exp_v); end
    step();
  endtask

  task automatic test_bypass();
    wr = 1; wr_addr = 2; d_in = 16'h5678;
    rd_addr_a = 2; rd_addr_b = 2;
    sb.push_back({32'h5678, 1'b1, 32'h5678, 1'b1});
    z_wr = 1; z_wr_addr = 9; z_d_in = 32'h5678;
    drive_zrd(9, 9);
    @(negedge clk);
    exp_v = sb.pop_front(); obs = {32'(d_out_a), valid_a, 32'(d_out_b), valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bypass: got %h exp %h", obs, exp_v); end
    exp_v = sb.pop_front(); obs = {z_d_out_a, z_valid_a, z_d_out_b, z_valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL no_bypass: got %h exp %h", obs, exp_v); end
    step();
    wr = 0; z_wr = 0;
    m_mem[2] = 16'h5678; m_val[2] = 1'b1;
    zm_mem[9] = 32'h5678; zm_val[9] = 1'b1;
    drive_zrd(9, 0);
    @(negedge clk);
    exp_v = sb.pop_front(); obs = {z_d_out_a, z_valid_a, z_d_out_b, z_valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL no_bypass_after: got %h exp %h", obs, exp_v); end
    step();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) wr_cycle(i, 16'(16'h1111 * i));
    clr = 1;
    wr = 1; wr_addr = 4; d_in = 16'hAAAA;
    rd_addr_a = 4; rd_addr_b = 3;
    sb.push_back({32'hAAAA, 1'b1, 32'(m_mem[3]), m_val[3]});
    @(negedge clk);
    exp_v = sb.pop_front(); obs = {32'(d_out_a), valid_a, 32'(d_out_b), valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL clr_wr_bypass: got %h exp %h", obs, exp_v); end
    step();
    clr = 0; wr = 0;
    m_mem[4] = 16'hAAAA; m_val[4] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive_rd(c, c == 0 ? 7 : c - 1);
      @(negedge clk);
      exp_v = sb.pop_front(); obs = {32'(d_out_a), valid_a, 32'(d_out_b), valid_b}; checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sweep_rd_c%0d: got %h exp %h", c, obs, exp_v); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy_c%0d: got %b exp 1", c, busy); end
      step();
      m_mem[c] = '0; m_val[c] = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL sweep_end_busy: got %b exp 0", busy); end
    for (int i = 0; i < 8; i += 2) begin
      drive_rd(i, i + 1);
      #1;
      exp_v = sb.pop_front(); obs = {32'(d_out_a), valid_a, 32'(d_out_b), valid_b}; checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sweep_final_%0d: got %h exp %h", i, obs, exp_v); end
    end
    step();
  endtask

  task automatic test_drop();
    wr_cycle(5, 16'h1234);
    wr_cycle(6, 16'h5555);
    clr = 1;
    step();
    clr = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin wr = 1; wr_addr = 5; d_in = 16'hBEEF; end
      if (c == 5) clr = 1;
      drive_rd(5, 6);
      @(negedge clk);
      exp_v = sb.pop_front(); obs = {32'(d_out_a), valid_a, 32'(d_out_b), valid_b}; checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL drop_rd_c%0d: got %h exp %h", c, obs, exp_v); end
      checks++;
      if ({busy, wr_drop} !== {c < 8, c == 4}) begin
        errors++; $display("FAIL drop_ctl_c%0d: got %b exp %b", c, {busy, wr_drop}, {c < 8, c == 4});
      end
      step();
      wr = 0; clr = 0;
      if (c < 8) begin m_mem[c] = '0; m_val[c] = 1'b0; end
    end
  endtask

  task automatic test_reset_mid();
    wr_cycle(6, 16'h6666);
    clr = 1;
    step();
    clr = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      m_mem[c] = '0; m_val[c] = 1'b0;
    end
    #2;
    reset_n = 0;
    model_reset();
    drive_rd(6, 5);
    #1;
    exp_v = sb.pop_front(); obs = {32'(d_out_a), valid_a, 32'(d_out_b), valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midrst_rd: got %h exp %h", obs, exp_v); end
    checks++;
    if ({busy, wr_drop} !== 2'b00) begin errors++; $display("FAIL midrst_ctl: got %b exp 00", {busy, wr_drop}); end
    @(negedge clk);
    reset_n = 1;
    step();
    wr_cycle(3, 16'h1234);
    drive_rd(3, 6);
    #1;
    exp_v = sb.pop_front(); obs = {32'(d_out_a), valid_a, 32'(d_out_b), valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL post_rst_wr: got %h exp %h", obs, exp_v); end
    checks++;
    if ({busy, wr_drop} !== 2'b00) begin errors++; $display("FAIL post_rst_ctl: got %b exp 00", {busy, wr_drop}); end
    step();
  endtask

  task automatic test_zero_reg();
    z_wr = 1; z_wr_addr = 0; z_d_in = 32'hFFFF;
    z_rd_a = 0; z_rd_b = 7;
    sb.push_back({32'h0, 1'b0, zm_mem[7], zm_val[7]});
    #1;
    exp_v = sb.pop_front(); obs = {z_d_out_a, z_valid_a, z_d_out_b, z_valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL zero_wr_same: got %h exp %h", obs, exp_v); end
    step();
    z_wr = 0;
    sb.push_back({32'h0, 1'b0, 32'h0, 1'b0});
    #1;
    exp_v = sb.pop_front(); obs = {z_d_out_a, z_valid_a, z_d_out_b, z_valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL zero_wr_after: got %h exp %h", obs, exp_v); end
    checks++;
    if (z_wr_drop !== 1'b0) begin errors++; $display("FAIL zero_drop: got %b exp 0", z_wr_drop); end
    z_wr = 1; z_wr_addr = 7; z_d_in = 32'hFFFF;
    drive_zrd(7, 15);
    #1;
    exp_v = sb.pop_front(); obs = {z_d_out_a, z_valid_a, z_d_out_b, z_valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL z7_same: got %h exp %h", obs, exp_v); end
    step();
    zm_mem[7] = 32'h0000FFFF; zm_val[7] = 1'b1;
    z_wr_addr = 15; z_d_in = 32'hDEADBEEF;
    step();
    z_wr = 0;
    zm_mem[15] = 32'hDEADBEEF; zm_val[15] = 1'b1;
    drive_zrd(7, 15);
    #1;
    exp_v = sb.pop_front(); obs = {z_d_out_a, z_valid_a, z_d_out_b, z_valid_b}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL z7_z15: got %h exp %h", obs, exp_v); end
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_drop();
    test_reset_mid();
    test_zero_reg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
